move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
//  Turn sequencer for the Location datapath. Latches cat/mouse direction requests, divides
//  clock into game ticks, issues one mouse move and one cat move per tick, alternating
//  first mover each round. Clears Location at game start and halts on GameOver.
// PARAMETERS
//  TICK_DIV  1000000  clock cycles per game tick (>=2); benches use 4
//  ROUND_W   8        width of Round counter
// PORTS
//  clock     in   1        system clock; all state updates on rising edge
//  reset     in   1        synchronous, active-high; clears all state
//  start     in   1        begin a new game (sampled in IDLE/DONE only)
//  pause     in   1        freezes tick countdown (level)
//  mouseReq  in   3        mouse player direction request (0 none,1 up,2 down,3 left,4 right)
//  catReq    in   3        cat player direction request, same encoding
//  GameOver  in   1        from Location
//  mouseDir  out  3        to Location.mouseDir; nonzero only in MOUSE-move cycle
//  catDir    out  3        to Location.catDir; nonzero only in CAT-move cycle
//  locReset  out  1        to Location.reset; 1-cycle pulse at game start
//  Round     out  ROUND_W  completed rounds this game, saturating
//  Running   out  1        1 in CLEAR/WAIT/FIRST/SECOND/SETTLE
//  Done      out  1        1 in DONE
// BEHAVIOUR
//  - All outputs registered; values valid during the cycle the FSM occupies the named state.
//  - reset: state=IDLE, mouseDir=catDir=0, locReset=0, Round=0, Running=0, Done=0,
//    both latches=0, mouseFirst=1, tick counter=TICK_DIV-1. Reset mid-move aborts immediately.
//  - States: IDLE, CLEAR, WAIT, FIRST, SECOND, SETTLE, DONE.
//    IDLE:   start=1 -> CLEAR.
//    CLEAR:  locReset=1 for exactly this cycle; Round=0, latches=0, mouseFirst=1,
//            counter=TICK_DIV-1 -> WAIT.
//    WAIT:   GameOver=1 -> DONE (priority). Else pause=1 holds counter. Else counter==0 ->
//            FIRST, otherwise counter decrements.
//    FIRST:  drive latch of first mover (mouse if mouseFirst) on its Dir output; other Dir=0.
//            Issued latch clears. -> SECOND (pause ignored).
//    SECOND: drive the other mover's latch; its latch clears. -> SETTLE.
//    SETTLE: both Dir=0; one cycle for Location outputs to update. GameOver=1 -> DONE;
//            else Round+=1 (hold at all-ones), mouseFirst toggles, counter=TICK_DIV-1 -> WAIT.
//    DONE:   Done=1, Running=0; Round/latches held; start=1 -> CLEAR.
//  - Latching: in CLEAR..SETTLE, a request of 1..4 overwrites its latch (last wins); 0 or
//    5..7 leaves latch unchanged. In IDLE/DONE requests ignored.
//  - Same-cycle issue and new valid request: issued value is the old latch; latch takes the
//    new request (not cleared), so it moves next round.
//  - Empty latch at issue: Dir output 0 that cycle (no move); sequencing unchanged.
//  - start asserted outside IDLE/DONE ignored. start and pause together in IDLE: start wins;
//    pause acts only in WAIT.
//  - Tick period with pause=0: WAIT lasts TICK_DIV cycles; round period = TICK_DIV+3 cycles.
// STRUCTURE
//  - Shared package game_pkg: DIR_NONE/UP/DOWN/LEFT/RIGHT (3-bit), dir_valid() helper,
//    scheduler state encoding; reused by Location and player-input blocks.
//  - Sub-module tick_divider (TICK_DIV param; load, hold, zero flag) owns the countdown.
//  - Top: FSM, two request latches, mouseFirst flag, Round counter, registered outputs.
// TESTING (TICK_DIV=4; CLEAR cycle = c)
//  - reset then start: locReset=1 only in cycle c; mouseReq=3 held, catReq=1 held ->
//    mouseDir=3 in c+5, catDir=1 in c+6, Round=1 from c+8.
//  - Alternation: round 2 issues catDir in c+12, mouseDir in c+13; round 3 mouse first again.
//  - Latching: mouseReq pulses 2 then 4 then 0 before tick -> mouseDir=4; no further request
//    -> next round mouseDir=0; mouseReq=6 alone -> never issued.
//  - pause=1 for 10 cycles during WAIT -> FIRST delayed exactly 10 cycles; pause in FIRST no effect.
//  - GameOver=1 in SETTLE -> Done=1, Running=0, Dir outputs 0, Round held; start -> locReset
//    pulse, Round=0. GameOver in WAIT -> DONE next cycle, no further moves.
//  - reset asserted in SECOND -> next cycle all outputs 0, IDLE; start ignored in WAIT.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: direction encoding, request validity helper and
// move scheduler state encoding.
package game_pkg;

    localparam int unsigned DIR_W   = 3;
    localparam int unsigned STATE_W = 3;

    localparam logic [DIR_W-1:0] DIR_NONE  = 3'd0;
    localparam logic [DIR_W-1:0] DIR_UP    = 3'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd3;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd4;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_FIRST  = 3'd3;
    localparam logic [STATE_W-1:0] ST_SECOND = 3'd4;
    localparam logic [STATE_W-1:0] ST_SETTLE = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

    // A request moves a player only if it names one of the four directions.
    function automatic logic dir_valid(input logic [DIR_W-1:0] d);
        return (d >= DIR_UP) && (d <= DIR_RIGHT);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Game tick countdown: loads TICK_DIV-1, counts down to zero unless held,
// and rests at zero until reloaded.
module tick_divider #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic hold_i,
    output logic zero_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_INIT;
        end else if (!hold_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= CNT_INIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/move_scheduler.sv
// Turn sequencer for the Location datapath: latches player requests, and per game
// tick issues one mouse and one cat move, alternating the first mover each round.
module move_scheduler
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned ROUND_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic [DIR_W-1:0]   mouseReq,
    input  logic [DIR_W-1:0]   catReq,
    input  logic               GameOver,
    output logic [DIR_W-1:0]   mouseDir,
    output logic [DIR_W-1:0]   catDir,
    output logic               locReset,
    output logic [ROUND_W-1:0] Round,
    output logic               Running,
    output logic               Done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [DIR_W-1:0]   mouse_lat_q, mouse_lat_d;
    logic [DIR_W-1:0]   cat_lat_q, cat_lat_d;
    logic               mouse_first_q, mouse_first_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [DIR_W-1:0]   mouse_dir_q, mouse_dir_d;
    logic [DIR_W-1:0]   cat_dir_q, cat_dir_d;
    logic               loc_reset_q, loc_reset_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               div_load, div_hold, div_zero;
    logic               req_en;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .load_i (div_load),
        .hold_i (div_hold),
        .zero_o (div_zero)
    );

    // Next state, latch updates and next registered outputs (tied to state_d so
    // each output is valid in the cycle its state is occupied).
    always_comb begin
        state_d       = state_q;
        mouse_lat_d   = mouse_lat_q;
        cat_lat_d     = cat_lat_q;
        mouse_first_d = mouse_first_q;
        round_d       = round_q;
        div_load      = 1'b0;
        div_hold      = 1'b1;
        mouse_dir_d   = DIR_NONE;
        cat_dir_d     = DIR_NONE;
        req_en        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                req_en   = 1'b1;
                div_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                req_en = 1'b1;
                if (GameOver)      state_d = ST_DONE;
                else if (!pause) begin
                    if (div_zero) state_d  = ST_FIRST;
                    else          div_hold = 1'b0;
                end
            end
            ST_FIRST: begin
                req_en  = 1'b1;
                state_d = ST_SECOND;
                if (mouse_first_q) mouse_lat_d = DIR_NONE;
                else               cat_lat_d   = DIR_NONE;
            end
            ST_SECOND: begin
                req_en  = 1'b1;
                state_d = ST_SETTLE;
                if (mouse_first_q) cat_lat_d   = DIR_NONE;
                else               mouse_lat_d = DIR_NONE;
            end
            ST_SETTLE: begin
                req_en = 1'b1;
                if (GameOver) begin
                    state_d = ST_DONE;
                end else begin
                    state_d       = ST_WAIT;
                    div_load      = 1'b1;
                    mouse_first_d = ~mouse_first_q;
                    if (round_q != '1) round_d = round_q + ROUND_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh request overrides a just-issued clear so it moves next round.
        if (req_en && dir_valid(mouseReq)) mouse_lat_d = mouseReq;
        if (req_en && dir_valid(catReq))   cat_lat_d   = catReq;

        if (state_d == ST_CLEAR) begin
            mouse_lat_d   = DIR_NONE;
            cat_lat_d     = DIR_NONE;
            round_d       = '0;
            mouse_first_d = 1'b1;
        end

        if (state_d == ST_FIRST) begin
            if (mouse_first_q) mouse_dir_d = mouse_lat_d;
            else               cat_dir_d   = cat_lat_d;
        end else if (state_d == ST_SECOND) begin
            if (mouse_first_q) cat_dir_d   = cat_lat_d;
            else               mouse_dir_d = mouse_lat_d;
        end

        loc_reset_d = (state_d == ST_CLEAR);
        running_d   = state_d inside {ST_CLEAR, ST_WAIT, ST_FIRST, ST_SECOND, ST_SETTLE};
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mouse_lat_q   <= DIR_NONE;
            cat_lat_q     <= DIR_NONE;
            mouse_first_q <= 1'b1;
            round_q       <= '0;
            mouse_dir_q   <= DIR_NONE;
            cat_dir_q     <= DIR_NONE;
            loc_reset_q   <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mouse_lat_q   <= mouse_lat_d;
            cat_lat_q     <= cat_lat_d;
            mouse_first_q <= mouse_first_d;
            round_q       <= round_d;
            mouse_dir_q   <= mouse_dir_d;
            cat_dir_q     <= cat_dir_d;
            loc_reset_q   <= loc_reset_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

    assign mouseDir = mouse_dir_q;
    assign catDir   = cat_dir_q;
    assign locReset = loc_reset_q;
    assign Round    = round_q;
    assign Running  = running_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with TICK_DIV=4; cycle offsets are relative
// to the CLEAR cycle c of each game.
module tb_move_scheduler;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned ROUND_W  = 8;

    logic               clock = 1'b0;
    logic               reset, start, pause, GameOver;
    logic [2:0]         mouseReq, catReq, mouseDir, catDir;
    logic               locReset, Running, Done;
    logic [ROUND_W-1:0] Round;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    move_scheduler #(.TICK_DIV(TICK_DIV), .ROUND_W(ROUND_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .mouseReq (mouseReq),
        .catReq   (catReq),
        .GameOver (GameOver),
        .mouseDir (mouseDir),
        .catDir   (catDir),
        .locReset (locReset),
        .Round    (Round),
        .Running  (Running),
        .Done     (Done)
    );

    // Advance into the next cycle; outputs read here belong to that cycle and
    // inputs set here are sampled at its closing edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset, then start a game; returns inside the CLEAR cycle c.
    task automatic begin_game(input logic [2:0] m, input logic [2:0] c);
        tick();
        reset = 1'b1; start = 1'b0; pause = 1'b0; GameOver = 1'b0;
        mouseReq = 3'd0; catReq = 3'd0;
        tick();
        reset = 1'b0; start = 1'b1; mouseReq = m; catReq = c;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; pause = 1'b0; GameOver = 1'b0;
        mouseReq = 3'd2; catReq = 3'd3;
        tick();
        tick();
        n_checks++;
        if ({mouseDir, catDir, locReset, Round, Running, Done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got md=%0d cd=%0d lr=%0b rnd=%0d run=%0b done=%0b exp all 0",
                     mouseDir, catDir, locReset, Round, Running, Done);
        end
        reset = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({Running, Done, locReset} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got run=%0b done=%0b lr=%0b exp 0 0 0", k, Running, Done, locReset);
            end
        end
    endtask

    task automatic test_basic_alternation();
        logic [2:0] mexp, cexp;
        logic [ROUND_W-1:0] rexp;
        begin_game(3'd3, 3'd1);
        n_checks++;
        if ({locReset, Running, Done} !== 3'b110 || Round !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_cycle: got lr=%0b run=%0b done=%0b rnd=%0d exp 1 1 0 0", locReset, Running, Done, Round);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            mexp = (k == 5 || k == 13 || k == 19) ? 3'd3 : 3'd0;
            cexp = (k == 6 || k == 12 || k == 20) ? 3'd1 : 3'd0;
            rexp = (k < 8) ? 8'd0 : (k < 15) ? 8'd1 : 8'd2;
            n_checks++;
            if (mouseDir !== mexp) begin
                n_fail++;
                $display("FAIL basic_mouseDir c+%0d: got %0d exp %0d", k, mouseDir, mexp);
            end
            n_checks++;
            if (catDir !== cexp) begin
                n_fail++;
                $display("FAIL basic_catDir c+%0d: got %0d exp %0d", k, catDir, cexp);
            end
            n_checks++;
            if (Round !== rexp) begin
                n_fail++;
                $display("FAIL basic_Round c+%0d: got %0d exp %0d", k, Round, rexp);
            end
            n_checks++;
            if (locReset !== 1'b0 || Running !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_flags c+%0d: got lr=%0b run=%0b exp 0 1", k, locReset, Running);
            end
        end
    endtask

    task automatic test_latching();
        logic [2:0] mexp;
        begin_game(3'd0, 3'd0);
        for (int k = 1; k <= 21; k++) begin
            tick();
            mexp = (k == 5) ? 3'd4 : 3'd0;
            n_checks++;
            if (mouseDir !== mexp) begin
                n_fail++;
                $display("FAIL latch_mouseDir c+%0d: got %0d exp %0d", k, mouseDir, mexp);
            end
            n_checks++;
            if (catDir !== 3'd0) begin
                n_fail++;
                $display("FAIL latch_catDir c+%0d: got %0d exp 0", k, catDir);
            end
            if (k == 1)       mouseReq = 3'd2;
            else if (k == 2)  mouseReq = 3'd4;
            else if (k == 3)  mouseReq = 3'd0;
            else if (k >= 14) mouseReq = 3'd6;
        end
    endtask

    task automatic test_pause();
        logic [2:0] mexp, cexp;
        tick();
        reset = 1'b1; start = 1'b0; pause = 1'b0; GameOver = 1'b0;
        tick();
        reset = 1'b0; start = 1'b1; pause = 1'b1; mouseReq = 3'd3; catReq = 3'd1;
        tick();
        n_checks++;
        if (locReset !== 1'b1) begin
            n_fail++;
            $display("FAIL start_beats_pause: got lr=%0b exp 1", locReset);
        end
        start = 1'b0; pause = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            mexp = (k == 15) ? 3'd3 : 3'd0;
            cexp = (k == 16) ? 3'd1 : 3'd0;
            n_checks++;
            if (mouseDir !== mexp || catDir !== cexp) begin
                n_fail++;
                $display("FAIL pause_dirs c+%0d: got md=%0d cd=%0d exp %0d %0d", k, mouseDir, catDir, mexp, cexp);
            end
            n_checks++;
            if (Round !== ((k >= 18) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL pause_Round c+%0d: got %0d exp %0d", k, Round, (k >= 18) ? 1 : 0);
            end
            if (k == 2 || k == 15)       pause = 1'b1;
            else if (k == 12 || k == 16) pause = 1'b0;
        end
    endtask

    task automatic test_gameover();
        logic [2:0] mexp, cexp;
        logic [ROUND_W-1:0] rexp;
        logic dexp, runexp, lexp;
        begin_game(3'd3, 3'd1);
        for (int k = 1; k <= 26; k++) begin
            tick();
            mexp   = (k == 5 || k == 13) ? 3'd3 : 3'd0;
            cexp   = (k == 6 || k == 12) ? 3'd1 : 3'd0;
            dexp   = (k == 15 || k == 16 || k >= 19);
            runexp = (k <= 14 || k == 17 || k == 18);
            lexp   = (k == 17);
            rexp   = (k < 8) ? 8'd0 : (k <= 16) ? 8'd1 : 8'd0;
            n_checks++;
            if (mouseDir !== mexp || catDir !== cexp) begin
                n_fail++;
                $display("FAIL go_dirs c+%0d: got md=%0d cd=%0d exp %0d %0d", k, mouseDir, catDir, mexp, cexp);
            end
            n_checks++;
            if (Done !== dexp || Running !== runexp || locReset !== lexp) begin
                n_fail++;
                $display("FAIL go_flags c+%0d: got done=%0b run=%0b lr=%0b exp %0b %0b %0b",
                         k, Done, Running, locReset, dexp, runexp, lexp);
            end
            n_checks++;
            if (Round !== rexp) begin
                n_fail++;
                $display("FAIL go_Round c+%0d: got %0d exp %0d", k, Round, rexp);
            end
            GameOver = (k == 14 || k == 18);
            start    = (k == 16);
        end
    endtask

    task automatic test_reset_mid_and_start_in_wait();
        begin_game(3'd3, 3'd1);
        for (int k = 1; k <= 6; k++) tick();
        n_checks++;
        if (catDir !== 3'd1) begin
            n_fail++;
            $display("FAIL second_catDir: got %0d exp 1", catDir);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({mouseDir, catDir, locReset, Round, Running, Done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got md=%0d cd=%0d lr=%0b rnd=%0d run=%0b done=%0b exp all 0",
                     mouseDir, catDir, locReset, Round, Running, Done);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (Running !== 1'b0 || mouseDir !== 3'd0) begin
            n_fail++;
            $display("FAIL after_reset_idle: got run=%0b md=%0d exp 0 0", Running, mouseDir);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        n_checks++;
        if (locReset !== 1'b0 || Running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_wait: got lr=%0b run=%0b exp 0 1", locReset, Running);
        end
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (mouseDir !== 3'd3) begin
            n_fail++;
            $display("FAIL start_in_wait_mouse: got %0d exp 3", mouseDir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_alternation();
        test_latching();
        test_pause();
        test_gameover();
        test_reset_mid_and_start_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
